// File: rtl/uart_sim_pkg.sv
// Shared types and helpers for the simulation UART endpoint.
// Parity modes, RX/TX state encodings and the parity-bit calculation.
package uart_sim_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    // Parity bit to transmit (or expect) for a zero-extended data word.
    function automatic logic parity_calc(input logic [7:0] data, input parity_e mode);
        case (mode)
            PARITY_EVEN: return ^data;
            PARITY_ODD:  return ~(^data);
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_sim_fifo.sv
// Synchronous FIFO for the UART RX path; pointers carry an extra MSB so
// full and empty are distinguishable. Head is presented as zero when empty.
module uart_sim_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push.
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data_i;
    end

    // NOTE: default assignment first so the combinational head mux cannot infer a latch.
    always_comb begin
        pop_data_o = '0;
        if (!empty_o) pop_data_o = mem[rd_ptr[AW-1:0]];
    end

endmodule

// File: rtl/uart_sim_core.sv
// Full-duplex simulation UART endpoint: TX via valid/ready, RX into a FIFO with sticky errors.
// Define UART_SIM_CONSOLE_EN to echo received bytes to the simulator console.
module uart_sim_core
    import uart_sim_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 16,
    parameter int DATA_BITS     = 8,
    parameter int PARITY_MODE   = 0,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic                 tx_o,
    input  logic                 rx_en_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    input  logic [DATA_BITS-1:0] tx_data_i,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_parity_err_o,
    output logic                 rx_frame_err_o,
    output logic                 rx_overflow_o,
    input  logic                 err_clr_i
);

    localparam int                CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_MAX    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_BIT   = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [2:0]        LAST_BIT   = 3'(DATA_BITS - 1);
    localparam logic              LAST_STOP  = 1'(STOP_BITS - 1);
    localparam bit                HAS_PARITY = (PARITY_MODE != 0);
    localparam parity_e           PMODE      = parity_e'(PARITY_MODE);

    // ---------------- RX ----------------
    logic                 rx_sync1, rx_sync2, rx_sync3;
    logic                 rx_line;
    logic                 rx_fall;
    rx_state_e            rx_state;
    logic [CNT_W-1:0]     rx_cnt;
    logic [2:0]           rx_bit_idx;
    logic                 rx_stop_idx;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_push;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 overflow_now;

    assign rx_line      = rx_sync2;
    assign rx_fall      = rx_sync3 && !rx_sync2;
    assign rx_valid_o   = !fifo_empty;
    assign fifo_pop     = rx_valid_o && rx_ready_i;
    assign overflow_now = rx_push && fifo_full && !fifo_pop;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_sync1        <= 1'b1;
            rx_sync2        <= 1'b1;
            rx_sync3        <= 1'b1;
            rx_state        <= RX_IDLE;
            rx_cnt          <= '0;
            rx_bit_idx      <= '0;
            rx_stop_idx     <= 1'b0;
            rx_shift        <= '0;
            rx_push         <= 1'b0;
            rx_parity_err_o <= 1'b0;
            rx_frame_err_o  <= 1'b0;
            rx_overflow_o   <= 1'b0;
        end else begin
            rx_sync1 <= rx_i;
            rx_sync2 <= rx_sync1;
            rx_sync3 <= rx_sync2;
            rx_push  <= 1'b0;

            // Clear first; any set later in this block overrides it.
            if (err_clr_i) begin
                rx_parity_err_o <= 1'b0;
                rx_frame_err_o  <= 1'b0;
                rx_overflow_o   <= 1'b0;
            end
            if (overflow_now) rx_overflow_o <= 1'b1;

            if (!rx_en_i) begin
                rx_state <= RX_IDLE;
            end else begin
                case (rx_state)
                    RX_IDLE: begin
                        if (rx_fall) begin
                            rx_state <= RX_START;
                            rx_cnt   <= HALF_BIT;
                        end
                    end
                    RX_START: begin
                        if (rx_cnt != '0) begin
                            rx_cnt <= rx_cnt - 1'b1;
                        end else if (!rx_line) begin
                            rx_state   <= RX_DATA;
                            rx_cnt     <= BIT_MAX;
                            rx_bit_idx <= '0;
                        end else begin
                            rx_state <= RX_IDLE;
                        end
                    end
                    RX_DATA: begin
                        if (rx_cnt != '0) begin
                            rx_cnt <= rx_cnt - 1'b1;
                        end else begin
                            rx_shift <= {rx_line, rx_shift[DATA_BITS-1:1]};
                            rx_cnt   <= BIT_MAX;
                            if (rx_bit_idx == LAST_BIT) begin
                                rx_stop_idx <= 1'b0;
                                rx_state    <= HAS_PARITY ? RX_PARITY : RX_STOP;
                            end else begin
                                rx_bit_idx <= rx_bit_idx + 1'b1;
                            end
                        end
                    end
                    RX_PARITY: begin
                        if (rx_cnt != '0) begin
                            rx_cnt <= rx_cnt - 1'b1;
                        end else begin
                            if (rx_line != parity_calc(8'(rx_shift), PMODE)) rx_parity_err_o <= 1'b1;
                            rx_cnt   <= BIT_MAX;
                            rx_state <= RX_STOP;
                        end
                    end
                    RX_STOP: begin
                        if (rx_cnt != '0) begin
                            rx_cnt <= rx_cnt - 1'b1;
                        end else begin
                            if (!rx_line) rx_frame_err_o <= 1'b1;
                            if (rx_stop_idx == LAST_STOP) begin
                                rx_push  <= 1'b1;
                                rx_state <= RX_IDLE;
                            end else begin
                                rx_stop_idx <= 1'b1;
                                rx_cnt      <= BIT_MAX;
                            end
                        end
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    uart_sim_fifo #(
        .DEPTH (RX_FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_rx_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (rx_push),
        .push_data_i (rx_shift),
        .pop_i       (fifo_pop),
        .pop_data_o  (rx_data_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // ---------------- TX ----------------
    tx_state_e            tx_state;
    logic [CNT_W-1:0]     tx_cnt;
    logic [2:0]           tx_bit_idx;
    logic                 tx_stop_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_state    <= TX_IDLE;
            tx_cnt      <= '0;
            tx_bit_idx  <= '0;
            tx_stop_idx <= 1'b0;
            tx_shift    <= '0;
            tx_par      <= 1'b0;
            tx_o        <= 1'b1;
            tx_ready_o  <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_o <= 1'b1;
                    if (tx_valid_i && tx_ready_o) begin
                        tx_shift   <= tx_data_i;
                        tx_par     <= parity_calc(8'(tx_data_i), PMODE);
                        tx_ready_o <= 1'b0;
                        tx_o       <= 1'b0;
                        tx_cnt     <= BIT_MAX;
                        tx_state   <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt != '0) begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end else begin
                        tx_o       <= tx_shift[0];
                        tx_shift   <= tx_shift >> 1;
                        tx_bit_idx <= '0;
                        tx_cnt     <= BIT_MAX;
                        tx_state   <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt != '0) begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end else begin
                        tx_cnt <= BIT_MAX;
                        if (tx_bit_idx == LAST_BIT) begin
                            tx_stop_idx <= 1'b0;
                            tx_o        <= HAS_PARITY ? tx_par : 1'b1;
                            tx_state    <= HAS_PARITY ? TX_PARITY : TX_STOP;
                        end else begin
                            tx_o       <= tx_shift[0];
                            tx_shift   <= tx_shift >> 1;
                            tx_bit_idx <= tx_bit_idx + 1'b1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_cnt != '0) begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end else begin
                        tx_o     <= 1'b1;
                        tx_cnt   <= BIT_MAX;
                        tx_state <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt != '0) begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end else if (tx_stop_idx == LAST_STOP) begin
                        tx_ready_o <= 1'b1;
                        tx_state   <= TX_IDLE;
                    end else begin
                        tx_stop_idx <= 1'b1;
                        tx_cnt      <= BIT_MAX;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

`ifdef UART_SIM_CONSOLE_EN
    logic line_start;
    logic perr_q, ferr_q, ovf_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            line_start <= 1'b1;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            perr_q <= rx_parity_err_o;
            ferr_q <= rx_frame_err_o;
            ovf_q  <= rx_overflow_o;
            if (rx_push) begin
                if (line_start) $write("[UART]: ");
                $write("%c", rx_shift);
                line_start <= (8'(rx_shift) == 8'h0A);
            end
            if (rx_parity_err_o && !perr_q) $display("[UART]: parity error");
            if (rx_frame_err_o && !ferr_q)  $display("[UART]: frame error");
            if (rx_overflow_o && !ovf_q)    $display("[UART]: rx overflow");
        end
    end
`else
    // Console echo disabled; datapath is unchanged.
`endif

endmodule
